mips_mc_core: RTL and testbench
===============================

# mips_mc_core

Multi-cycle, parametrised successor to the 16-bit single-cycle MIPS core. It executes the same 16-bit instruction format over a configurable datapath width, using one shared instruction/data memory port with a ready handshake. A five-state FSM sequences each instruction, so the core tolerates wait states. It exposes debug/observation outputs for the FPGA top level.

## Interface
- `DATA_W`, 16: register/ALU/address width; legal values 16 or 32.
- `RESET_PC`, 0: PC value loaded on reset; must be even.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `mem_req` out 1: transfer request; high in FETCH and MEM.
- `mem_we` out 1: write strobe; high only in MEM for `sw`.
- `mem_addr` out DATA_W: byte address; PC in FETCH, ALU result in MEM.
- `mem_wdata` out DATA_W: store data (rt).
- `mem_rdata` in DATA_W: read data; instruction is bits [15:0].
- `mem_ready` in 1: transfer completes on an edge where `mem_req` and `mem_ready` are both high.
- `pc_out` out DATA_W: current PC.
- `alu_result` out DATA_W: registered ALU output.
- `halted` out 1: core stopped.
- `retire_count` out DATA_W: instructions retired.

## Operation
- Instruction fields:
  - op = [15:13], rs = [12:10], rt = [9:7], rd = [6:4], funct = [3:0].
  - imm7 = [6:0], sign-extended to DATA_W.
  - jtarget = {pc2[DATA_W-1:14], instr[12:0], 1'b0}.
  - pc2 = PC + 2.
- Register file: 8 × DATA_W; r0 reads 0 and ignores writes; asynchronous read, write on clock edge.
- Opcodes:
  - 000 R-type, by funct: 0 add, 1 sub, 2 and, 3 or, 4 slt (signed), 8 jr. Any other funct executes as a nop and still retires.
  - 001 addi: rt = rs + imm.
  - 010 lw: rt = mem[rs + imm].
  - 011 sw: mem[rs + imm] = rt.
  - 100 beq: if rs == rt, PC = pc2 + (imm << 1).
  - 101 j; 110 jal: r7 = pc2, then jump. 111 halt.
- Arithmetic wraps modulo 2^DATA_W; no overflow trap.
- FSM states and transitions:
  - FETCH: hold `mem_req`; on completion latch IR, then go to DECODE.
  - DECODE: j/jal/jr update PC (jal writes r7), retire, go to FETCH. halt goes to HALT. All others go to EXEC.
  - EXEC: ALU result latched into `alu_result`. beq resolves PC and retires, then FETCH. lw/sw go to MEM. R-type/addi go to WB.
  - MEM: hold `mem_req` until ready. sw retires on completion, then FETCH. lw latches MDR, then WB.
  - WB: write rd (R-type) or rt (addi, lw), retire, go to FETCH.
  - HALT: absorbing; `halted` = 1; leaves only on reset.
- PC update for non-jumps: PC = pc2, applied at the retiring edge.
- `retire_count` increments by 1 per retired instruction and wraps. halt itself is not counted.

## Timing
- Reset values (asynchronous): PC = RESET_PC, state = FETCH, all registers 0, `alu_result` 0, `halted` 0, `retire_count` 0, IR 0, MDR 0.
- During reset, `mem_req` and `mem_we` are forced 0.
- Cycles per instruction with zero-wait memory:
  - j/jal/jr: 2.
  - beq: 3.
  - R-type, addi, sw: 4.
  - lw: 5.
- Each wait cycle on `mem_ready` adds 1 cycle.
- Zero-wait: `mem_ready` may be high in the first request cycle; the transfer completes at that edge.
- While `mem_req` is high, `mem_addr`, `mem_we`, and `mem_wdata` stay stable.
- `mem_ready` seen while `mem_req` is low is ignored.
- Reset asserted mid-transfer abandons the transfer: `mem_req` drops immediately and no register or PC update occurs.
- jal with rd = r7 collision: the r7 write takes effect. A branch or jump to its own address loops legally.

## Structure
- `mips_mc_pkg`: opcode and funct constants, FSM state enum, ALU-op enum.
- Sub-module `mips_mc_regfile` (parametrised on DATA_W; r0 hardwired to zero).
- ALU and FSM stay inline in `mips_mc_core`.

## Test plan
- Zero-wait, DATA_W=16: `addi r1,r0,5`; `addi r2,r0,-3`; `add r3,r1,r2` → r3 = 2. `retire_count` = 3 after 12 cycles.
- Store then load with 2 wait states on every transfer: `sw` then `lw` → loaded value equals stored value. `lw` takes 9 cycles. `mem_addr` and `mem_wdata` stay stable while waiting.
- beq: taken with imm = -2 → PC = pc2 - 4; not taken → PC = pc2. Each takes 3 cycles.
- `jal` at PC 0x0010 → r7 = 0x0012, PC = jtarget. Following `jr r7` → PC = 0x0012.
- DATA_W=32: `sub` of 0 - 1 → 0xFFFFFFFF; `slt` with (-1, 1) → 1.
- `reset` asserted during MEM of `sw` → no write, `mem_req` drops the same cycle, PC = RESET_PC. A halt instruction → `halted` = 1 and the core stays halted with no further `mem_req`.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multi-cycle MIPS core: opcodes, R-type functs,
// FSM states and the ALU operation select.
package mips_mc_pkg;

    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_ADDI  = 3'b001;
    localparam logic [2:0] OP_LW    = 3'b010;
    localparam logic [2:0] OP_SW    = 3'b011;
    localparam logic [2:0] OP_BEQ   = 3'b100;
    localparam logic [2:0] OP_J     = 3'b101;
    localparam logic [2:0] OP_JAL   = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam logic [3:0] FN_ADD = 4'd0;
    localparam logic [3:0] FN_SUB = 4'd1;
    localparam logic [3:0] FN_AND = 4'd2;
    localparam logic [3:0] FN_OR  = 4'd3;
    localparam logic [3:0] FN_SLT = 4'd4;
    localparam logic [3:0] FN_JR  = 4'd8;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_NOP
    } alu_op_t;

    // Address-forming opcodes add; beq compares by subtraction; unknown
    // R-type functs become NOP so WB can suppress the register write.
    function automatic alu_op_t alu_decode(input logic [2:0] op, input logic [3:0] funct);
        alu_op_t r;
        r = ALU_ADD;
        if (op == OP_RTYPE) begin
            case (funct)
                FN_ADD:  r = ALU_ADD;
                FN_SUB:  r = ALU_SUB;
                FN_AND:  r = ALU_AND;
                FN_OR:   r = ALU_OR;
                FN_SLT:  r = ALU_SLT;
                default: r = ALU_NOP;
            endcase
        end else if (op == OP_BEQ) begin
            r = ALU_SUB;
        end
        return r;
    endfunction

endpackage

// File: rtl/mips_mc_regfile.sv
// 8-entry register file: two asynchronous read ports, one write port,
// r0 hardwired to zero.
module mips_mc_regfile #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [2:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [2:0]        raddr_a,
    input  logic [2:0]        raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs [8];

    // Register storage; writes to r0 are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else if (we && (waddr != 3'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == 3'd0) ? '0 : regs[raddr_a];
    assign rdata_b = (raddr_b == 3'd0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/mips_mc_core.sv
// Multi-cycle 16-bit-ISA MIPS core over a DATA_W datapath with a single
// shared memory port. FETCH/DECODE/EXEC/MEM/WB sequence each instruction and
// stall in FETCH or MEM until mem_ready.
module mips_mc_core
    import mips_mc_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] alu_result,
    output logic              halted,
    output logic [DATA_W-1:0] retire_count
);

    state_t                   state;
    logic [DATA_W-1:0]        pc, pc2, imm, jtarget, br_target;
    logic [DATA_W-1:0]        alu_q, mdr, retire_cnt, alu_y;
    logic [DATA_W-1:0]        rs_val, rt_val, rf_wdata;
    logic [15:0]              ir;
    logic [2:0]               op, rs, rt, rd, rf_waddr;
    logic [3:0]               funct;
    logic                     rf_we, halted_q, xfer;
    alu_op_t                  alu_op;
    logic signed [DATA_W-1:0] opa_s, opb_s;

    assign op        = ir[15:13];
    assign rs        = ir[12:10];
    assign rt        = ir[9:7];
    assign rd        = ir[6:4];
    assign funct     = ir[3:0];
    assign imm       = {{(DATA_W-7){ir[6]}}, ir[6:0]};
    assign pc2       = pc + DATA_W'(2);
    assign jtarget   = {pc2[DATA_W-1:14], ir[12:0], 1'b0};
    assign br_target = pc2 + (imm << 1);

    mips_mc_regfile #(.DATA_W(DATA_W)) u_rf (
        .clk     (clk),
        .reset   (reset),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (rs),
        .raddr_b (rt),
        .rdata_a (rs_val),
        .rdata_b (rt_val)
    );

    // ALU: second operand is rt for R-type/beq, sign-extended imm otherwise.
    always_comb begin
        alu_op = alu_decode(op, funct);
        opa_s  = rs_val;
        opb_s  = ((op == OP_RTYPE) || (op == OP_BEQ)) ? rt_val : imm;
        alu_y  = '0;
        case (alu_op)
            ALU_ADD: alu_y = opa_s + opb_s;
            ALU_SUB: alu_y = opa_s - opb_s;
            ALU_AND: alu_y = opa_s & opb_s;
            ALU_OR:  alu_y = opa_s | opb_s;
            ALU_SLT: alu_y = {{(DATA_W-1){1'b0}}, (opa_s < opb_s)};
            default: alu_y = '0;
        endcase
    end

    // Register write port: jal links r7 in DECODE, everything else writes in WB.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = rt;
        rf_wdata = alu_q;
        if (state == ST_DECODE && op == OP_JAL) begin
            rf_we    = 1'b1;
            rf_waddr = 3'd7;
            rf_wdata = pc2;
        end else if (state == ST_WB) begin
            rf_we    = (op != OP_RTYPE) || (alu_op != ALU_NOP);
            rf_waddr = (op == OP_RTYPE) ? rd : rt;
            rf_wdata = (op == OP_LW) ? mdr : alu_q;
        end
    end

    // Request is gated by reset so an in-flight transfer is dropped at once.
    assign mem_req   = ~reset & ((state == ST_FETCH) | (state == ST_MEM));
    assign mem_we    = ~reset & (state == ST_MEM) & (op == OP_SW);
    assign mem_addr  = (state == ST_MEM) ? alu_q : pc;
    assign mem_wdata = rt_val;
    assign xfer      = mem_req & mem_ready;

    // Instruction sequencer: PC, IR, MDR, ALU latch and retire counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_FETCH;
            pc         <= RESET_PC;
            ir         <= '0;
            mdr        <= '0;
            alu_q      <= '0;
            halted_q   <= 1'b0;
            retire_cnt <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (xfer) begin
                        ir    <= mem_rdata[15:0];
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (op == OP_J || op == OP_JAL) begin
                        pc         <= jtarget;
                        retire_cnt <= retire_cnt + DATA_W'(1);
                        state      <= ST_FETCH;
                    end else if (op == OP_HALT) begin
                        halted_q <= 1'b1;
                        state    <= ST_HALT;
                    end else if (op == OP_RTYPE && funct == FN_JR) begin
                        pc         <= rs_val;
                        retire_cnt <= retire_cnt + DATA_W'(1);
                        state      <= ST_FETCH;
                    end else begin
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    alu_q <= alu_y;
                    if (op == OP_BEQ) begin
                        pc         <= (rs_val == rt_val) ? br_target : pc2;
                        retire_cnt <= retire_cnt + DATA_W'(1);
                        state      <= ST_FETCH;
                    end else if (op == OP_LW || op == OP_SW) begin
                        state <= ST_MEM;
                    end else begin
                        state <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (xfer) begin
                        if (op == OP_SW) begin
                            pc         <= pc2;
                            retire_cnt <= retire_cnt + DATA_W'(1);
                            state      <= ST_FETCH;
                        end else begin
                            mdr   <= mem_rdata;
                            state <= ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    pc         <= pc2;
                    retire_cnt <= retire_cnt + DATA_W'(1);
                    state      <= ST_FETCH;
                end
                default: state <= ST_HALT;
            endcase
        end
    end

    assign pc_out       = pc;
    assign alu_result   = alu_q;
    assign halted       = halted_q;
    assign retire_count = retire_cnt;

endmodule

// File: tb/tb_mips_mc_core.sv
// Bench for mips_mc_core: a 16-bit and a 32-bit instance share one clock,
// each with a behavioural memory that can insert wait states. Programs come
// from vector tables; each retirement is checked against a queue of
// expected PC / register value / cycle count.
module tb_mips_mc_core;
    import mips_mc_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst16, rst32;
    logic        req16, we16, ready16, halt16;
    logic [15:0] addr16, wdata16, rdata16, pc16, alu16, rc16;
    logic        req32, we32, ready32, halt32;
    logic [31:0] addr32, wdata32, rdata32, pc32, alu32, rc32;

    mips_mc_core #(.DATA_W(16), .RESET_PC(16'h0000)) dut16 (
        .clk(clk), .reset(rst16), .mem_req(req16), .mem_we(we16),
        .mem_addr(addr16), .mem_wdata(wdata16), .mem_rdata(rdata16),
        .mem_ready(ready16), .pc_out(pc16), .alu_result(alu16),
        .halted(halt16), .retire_count(rc16));

    mips_mc_core #(.DATA_W(32), .RESET_PC(32'h0000_0100)) dut32 (
        .clk(clk), .reset(rst32), .mem_req(req32), .mem_we(we32),
        .mem_addr(addr32), .mem_wdata(wdata32), .mem_rdata(rdata32),
        .mem_ready(ready32), .pc_out(pc32), .alu_result(alu32),
        .halted(halt32), .retire_count(rc32));

    logic [15:0] mem16 [256];
    logic [31:0] mem32 [256];
    int          wait16, wcnt16;
    logic        pend16, s_we;
    logic [15:0] s_addr, s_wdata;

    int n_cmp = 0;
    int n_bad = 0;

    logic sel32;
    wire [31:0] a_pc   = sel32 ? pc32 : {16'h0, pc16};
    wire [31:0] a_rc   = sel32 ? rc32 : {16'h0, rc16};
    wire        a_halt = sel32 ? halt32 : halt16;
    wire        a_req  = sel32 ? req32 : req16;
    wire        a_rst  = sel32 ? rst32 : rst16;

    typedef struct {
        logic [31:0] pc;
        int          ridx;
        logic [31:0] val;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] instr;
        logic [31:0] pc;
        int          ridx;
        logic [31:0] val;
        int          cyc;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[$];
    int   cyc, last_rc, last_cyc, n_ret;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] enc_r(input int rs, input int rt, input int rd, input int fn);
        return {OP_RTYPE, rs[2:0], rt[2:0], rd[2:0], fn[3:0]};
    endfunction

    function automatic logic [15:0] enc_i(input logic [2:0] op, input int rs, input int rt, input int imm);
        return {op, rs[2:0], rt[2:0], imm[6:0]};
    endfunction

    function automatic logic [15:0] enc_j(input logic [2:0] op, input int tgt);
        return {op, tgt[12:0]};
    endfunction

    function automatic logic [31:0] get_reg(input int i);
        logic [2:0] k;
        k = i[2:0];
        if (sel32) return dut32.u_rf.regs[k];
        return {16'h0, dut16.u_rf.regs[k]};
    endfunction

    // Memory responders, evaluated once per cycle after the falling edge.
    // mem_ready is driven high whenever there is no request, which the
    // core has to ignore.
    task automatic mem_eval();
        if (req16) begin
            if (pend16) begin
                chk("stable_addr", {16'h0, addr16}, {16'h0, s_addr});
                chk("stable_wdata", {16'h0, wdata16}, {16'h0, s_wdata});
                chk("stable_we", {31'h0, we16}, {31'h0, s_we});
            end
            if (wcnt16 >= wait16) begin
                ready16 = 1'b1;
                if (we16) mem16[addr16[8:1]] = wdata16;
                rdata16 = mem16[addr16[8:1]];
                wcnt16  = 0;
                pend16  = 1'b0;
            end else begin
                ready16 = 1'b0;
                rdata16 = 16'hDEAD;
                wcnt16++;
                pend16  = 1'b1;
                s_addr  = addr16;
                s_wdata = wdata16;
                s_we    = we16;
            end
        end else begin
            ready16 = 1'b1;
            rdata16 = 16'hBEEF;
            wcnt16  = 0;
            pend16  = 1'b0;
        end
        if (req32) begin
            ready32 = 1'b1;
            if (we32) mem32[addr32[8:1]] = wdata32;
            rdata32 = mem32[addr32[8:1]];
        end else begin
            ready32 = 1'b1;
            rdata32 = 32'hBEEF_BEEF;
        end
    endtask

    // Scoreboard: compare each retirement with the next queued expectation.
    task automatic monitor();
        exp_t e;
        if (!a_rst) begin
            cyc++;
            if (a_rc != last_rc) begin
                n_ret++;
                chk($sformatf("retire_step[%0d]", n_ret), a_rc, last_rc + 1);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_retire: got retire_count %0d, expected no retirement", a_rc);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("pc[%0d]", n_ret), a_pc, e.pc);
                    chk($sformatf("r%0d[%0d]", e.ridx, n_ret), get_reg(e.ridx), e.val);
                    chk($sformatf("cycles[%0d]", n_ret), cyc - last_cyc, e.cyc);
                end
                last_rc  = a_rc;
                last_cyc = cyc;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
        mem_eval();
        monitor();
    endtask

    task automatic do_reset();
        rst16 = 1'b1;
        rst32 = 1'b1;
        for (int i = 0; i < 256; i++) begin
            mem16[i] = '0;
            mem32[i] = '0;
        end
        exp_q.delete();
        tbl.delete();
        #1;
        mem_eval();
        step();
        step();
    endtask

    task automatic release_dut();
        if (sel32) rst32 = 1'b0;
        else rst16 = 1'b0;
        cyc      = 0;
        last_rc  = 0;
        last_cyc = 0;
        n_ret    = 0;
        #1;
        mem_eval();
    endtask

    task automatic add_vec(input int addr, input logic [15:0] instr, input int pc,
                           input int ridx, input int val, input int c);
        vec_t v;
        v.addr  = addr[15:0];
        v.instr = instr;
        v.pc    = pc;
        v.ridx  = ridx;
        v.val   = val;
        v.cyc   = c;
        tbl.push_back(v);
    endtask

    task automatic load_tbl();
        exp_t e;
        foreach (tbl[i]) begin
            if (sel32) mem32[tbl[i].addr[8:1]] = {16'h0, tbl[i].instr};
            else       mem16[tbl[i].addr[8:1]] = tbl[i].instr;
            e.pc   = tbl[i].pc;
            e.ridx = tbl[i].ridx;
            e.val  = tbl[i].val;
            e.cyc  = tbl[i].cyc;
            exp_q.push_back(e);
        end
    endtask

    task automatic run(input int max_cycles);
        int n = 0;
        while (exp_q.size() > 0 && n < max_cycles) begin
            step();
            n++;
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got %0d retirements outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_halt(input string tag);
        int          n = 0;
        logic        saw;
        logic [31:0] rc0, pc0;
        while (a_halt !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        chk({tag, "_halted"}, {31'h0, a_halt}, 32'd1);
        rc0 = a_rc;
        pc0 = a_pc;
        saw = 1'b0;
        repeat (10) begin
            step();
            if (a_req) saw = 1'b1;
        end
        chk({tag, "_no_req"}, {31'h0, saw}, 32'd0);
        chk({tag, "_halt_rc"}, a_rc, rc0);
        chk({tag, "_halt_pc"}, a_pc, pc0);
        chk({tag, "_still_halted"}, {31'h0, a_halt}, 32'd1);
    endtask

    initial begin
        int n;
        sel32   = 1'b0;
        wait16  = 0;
        wcnt16  = 0;
        pend16  = 1'b0;
        s_we    = 1'b0;
        s_addr  = '0;
        s_wdata = '0;
        ready16 = 1'b0;
        ready32 = 1'b0;
        rdata16 = '0;
        rdata32 = '0;
        do_reset();

        // Reset state of both instances.
        chk("rst_req16", {31'h0, req16}, 32'd0);
        chk("rst_we16", {31'h0, we16}, 32'd0);
        chk("rst_pc16", {16'h0, pc16}, 32'h0);
        chk("rst_rc16", {16'h0, rc16}, 32'h0);
        chk("rst_alu16", {16'h0, alu16}, 32'h0);
        chk("rst_halt16", {31'h0, halt16}, 32'd0);
        chk("rst_req32", {31'h0, req32}, 32'd0);
        chk("rst_pc32", pc32, 32'h100);

        // 16-bit, zero-wait program: ALU ops, nop funct, jal/jr, beq, j, sw/lw.
        add_vec(16'h00, enc_i(OP_ADDI, 0, 1, 5),     32'h02, 1, 32'h0005, 4);
        add_vec(16'h02, enc_i(OP_ADDI, 0, 2, -3),    32'h04, 2, 32'hFFFD, 4);
        add_vec(16'h04, enc_r(1, 2, 3, 0),           32'h06, 3, 32'h0002, 4);
        add_vec(16'h06, enc_r(1, 2, 4, 1),           32'h08, 4, 32'h0008, 4);
        add_vec(16'h08, enc_r(1, 2, 5, 2),           32'h0A, 5, 32'h0005, 4);
        add_vec(16'h0A, enc_r(1, 2, 6, 3),           32'h0C, 6, 32'hFFFD, 4);
        add_vec(16'h0C, enc_r(2, 1, 4, 4),           32'h0E, 4, 32'h0001, 4);
        add_vec(16'h0E, enc_r(1, 2, 3, 5),           32'h10, 3, 32'h0002, 4);
        add_vec(16'h10, enc_j(OP_JAL, 13'h070),      32'hE0, 7, 32'h0012, 2);
        add_vec(16'hE0, enc_i(OP_ADDI, 0, 0, 7),     32'hE2, 0, 32'h0000, 4);
        add_vec(16'hE2, enc_r(7, 0, 0, 8),           32'h12, 7, 32'h0012, 2);
        add_vec(16'h12, enc_i(OP_BEQ, 1, 2, -2),     32'h14, 1, 32'h0005, 3);
        add_vec(16'h14, enc_i(OP_BEQ, 1, 1, 3),      32'h1C, 1, 32'h0005, 3);
        add_vec(16'h1C, enc_i(OP_BEQ, 0, 0, -2),     32'h1A, 2, 32'hFFFD, 3);
        add_vec(16'h1A, enc_j(OP_J, 13'h018),        32'h30, 2, 32'hFFFD, 2);
        add_vec(16'h30, enc_i(OP_SW, 0, 6, 32'h20),  32'h32, 6, 32'hFFFD, 4);
        add_vec(16'h32, enc_i(OP_LW, 0, 5, 32'h20),  32'h34, 5, 32'hFFFD, 5);
        load_tbl();
        mem16[8'h1A] = enc_j(OP_HALT, 0);
        release_dut();
        run(400);
        chk("t1_store", {16'h0, mem16[8'h10]}, 32'hFFFD);
        chk("t1_alu_result", {16'h0, alu16}, 32'h0020);
        check_halt("t1");

        // Store then load with two wait states on every transfer.
        do_reset();
        wait16 = 2;
        add_vec(16'h00, enc_i(OP_ADDI, 0, 1, 32'h15), 32'h02, 1, 32'h0015, 6);
        add_vec(16'h02, enc_i(OP_SW, 0, 1, 32'h22),   32'h04, 1, 32'h0015, 8);
        add_vec(16'h04, enc_i(OP_LW, 0, 2, 32'h22),   32'h06, 2, 32'h0015, 9);
        load_tbl();
        mem16[8'h03] = enc_j(OP_HALT, 0);
        release_dut();
        run(200);
        chk("t2_store", {16'h0, mem16[8'h11]}, 32'h0015);
        check_halt("t2");

        // Reset while a store waits in MEM: the write must never land.
        do_reset();
        wait16 = 3;
        add_vec(16'h00, enc_i(OP_ADDI, 0, 1, 9), 32'h02, 1, 32'h0009, 7);
        load_tbl();
        mem16[8'h01] = enc_i(OP_SW, 0, 1, 32'h24);
        release_dut();
        run(100);
        n = 0;
        while (!(we16 === 1'b1 && wcnt16 == 1) && n < 50) begin
            step();
            n++;
        end
        chk("t3_in_mem_sw", {31'h0, we16}, 32'd1);
        rst16 = 1'b1;
        #1;
        chk("t3_req_drop", {31'h0, req16}, 32'd0);
        chk("t3_we_drop", {31'h0, we16}, 32'd0);
        chk("t3_pc_reset", {16'h0, pc16}, 32'h0);
        chk("t3_rc_reset", {16'h0, rc16}, 32'h0);
        mem_eval();
        repeat (3) step();
        chk("t3_no_write", {16'h0, mem16[8'h12]}, 32'h0);
        chk("t3_r1_reset", get_reg(1), 32'h0);
        mem16[8'h00] = enc_j(OP_HALT, 0);
        wait16 = 0;
        release_dut();
        check_halt("t3");
        chk("t3_rc_zero", {16'h0, rc16}, 32'h0);

        // 32-bit datapath from RESET_PC 0x100.
        do_reset();
        sel32 = 1'b1;
        add_vec(16'h100, enc_i(OP_ADDI, 0, 1, 1),  32'h102, 1, 32'h0000_0001, 4);
        add_vec(16'h102, enc_r(0, 1, 2, 1),        32'h104, 2, 32'hFFFF_FFFF, 4);
        add_vec(16'h104, enc_i(OP_ADDI, 0, 3, -1), 32'h106, 3, 32'hFFFF_FFFF, 4);
        add_vec(16'h106, enc_r(3, 1, 4, 4),        32'h108, 4, 32'h0000_0001, 4);
        add_vec(16'h108, enc_r(1, 3, 5, 4),        32'h10A, 5, 32'h0000_0000, 4);
        load_tbl();
        mem32[8'h85] = {16'h0, enc_j(OP_HALT, 0)};
        release_dut();
        run(200);
        chk("t4_alu_result", alu32, 32'h0);
        check_halt("t4");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
